// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and a small width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  // Tick index at the middle of the start bit, measured from the detected edge.
  localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  // Tick index one full bit after the previous mid-bit sample.
  localparam logic [TICK_W-1:0] BIT_TICK = TICK_W'(OVERSAMPLE - 1);

  // Counter width able to index n items; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so idle-high serial lines do not produce a spurious edge out
// of reset.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver driven by a 16x oversample tick, presenting each good
// byte on an AXI4-Stream master port. Bad stop bits and bytes that arrive
// while the output register is still occupied are reported as single-cycle
// pulses and the byte is discarded.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned       BIT_W    = cnt_width(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 prev_q;
  rx_state_e            state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] tdata_q;
  logic                 tvalid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic                 fall_d;
  logic                 accept_d;
  logic                 room_d;
  logic [TICK_W-1:0]    tick_inc_d;

  rx_sync #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  // Shared decodes: start edge, downstream acceptance and output-register room.
  always_comb begin
    fall_d     = prev_q & ~rx_s;
    accept_d   = tvalid_q & m_axis_tready;
    room_d     = ~tvalid_q | m_axis_tready;
    tick_inc_d = tick_cnt_q + TICK_W'(1);
  end

  // Receive state machine together with the AXI output register and error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prev_q      <= 1'b1;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A handshake empties the register; a load in the same cycle overrides below.
      if (accept_d) begin
        tvalid_q <= 1'b0;
      end

      if (baud_i) begin
        prev_q <= rx_s;

        unique case (state_q)
          IDLE: begin
            // Edge-triggered so a line stuck low cannot start a new frame.
            if (fall_d) begin
              tick_cnt_q <= '0;
              state_q    <= START;
            end
          end

          START: begin
            if (tick_cnt_q == MID_TICK) begin
              if (!rx_s) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                state_q    <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_inc_d;
            end
          end

          DATA: begin
            tick_cnt_q <= tick_inc_d;
            if (tick_cnt_q == BIT_TICK) begin
              sh_q <= {rx_s, sh_q[DATA_BITS-1:1]};
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              end
            end
          end

          STOP: begin
            tick_cnt_q <= tick_inc_d;
            if (tick_cnt_q == BIT_TICK) begin
              // Returning to IDLE at mid stop bit lets a back-to-back start edge be seen.
              state_q <= IDLE;
              if (rx_s) begin
                if (room_d) begin
                  tdata_q  <= sh_q;
                  tvalid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_o     = overrun_q;

endmodule
